inst_fetch_queue: RTL and testbench

//  Instruction fetch queue plus IF/ID pipeline register, directly downstream of the PC register/instruction ROM.

---
 rtl/inst_fetch_queue.sv | 81 ++++++++
 tb/tb_inst_fetch_queue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction fetch FIFO plus IF/ID output register, one instruction per cycle to decode
//   clk, rst (async, active-low)
//   stall[1] holds the output stage; flush discards queue, output stage and the current fetch
//   if_valid_i/if_pc_i/if_inst_i: fetch response in; if_ready_o: queue has room
//   stallreq_o: queue full, freezes the PC upstream
//   id_valid_o/id_pc_o/id_inst_o: decode-side output stage; count_o: queue occupancy
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              if_valid_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  input  logic [DATA_W-1:0] if_inst_i,
  output logic              if_ready_o,
  output logic              stallreq_o,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o,
  output logic [CW-1:0]     count_o
);
  logic [ADDR_W-1:0] mem_pc_q [DEPTH];
  logic [DATA_W-1:0] mem_inst_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic vld_q, vld_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic push, adv, pop, wr_en, zero_out;
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};
  assign if_ready_o = cnt_q != CW'(DEPTH);
  assign stallreq_o = cnt_q == CW'(DEPTH);
  assign count_o = cnt_q;
  assign id_valid_o = vld_q;
  assign id_pc_o = pc_q;
  assign id_inst_o = inst_q;
  always_comb begin
    push = if_valid_i & if_ready_o & ~flush;
    adv = ~stall[1] & ~flush;
    pop = adv & (cnt_q != '0);
    // an empty queue under advance bypasses straight to the output stage, so only store otherwise
    wr_en = push & (pop | ~adv);
    zero_out = flush | (adv & ~pop & ~push);
    wr_d = flush ? '0 : wr_q + PW'(wr_en);
    rd_d = flush ? '0 : rd_q + PW'(pop);
    cnt_d = flush ? '0 : cnt_q + CW'(wr_en) - CW'(pop);
    vld_d = flush ? 1'b0 : adv ? (pop | push) : vld_q;
    pc_d = zero_out ? '0 : ~adv ? pc_q : pop ? mem_pc_q[rd_q] : if_pc_i;
    inst_d = zero_out ? '0 : ~adv ? inst_q : pop ? mem_inst_q[rd_q] : if_inst_i;
  end
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_pc_q[wr_q] <= if_pc_i;
      mem_inst_q[wr_q] <= if_inst_i;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
      pc_q <= '0;
      inst_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: table vectors plus queue scoreboard for inst_fetch_queue
module tb_inst_fetch_queue;
  logic clk = 1'b0;
  logic rst;
  logic [5:0] stall;
  logic flush, if_valid_i;
  logic [31:0] if_pc_i, if_inst_i;
  logic if_ready_o, stallreq_o, id_valid_o;
  logic [31:0] id_pc_o, id_inst_o;
  logic [2:0] count_o;
  inst_fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i),
    .if_ready_o(if_ready_o), .stallreq_o(stallreq_o),
    .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
    .count_o(count_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  typedef struct {
    logic s, f, v;
    logic [31:0] pc;
    logic ev;
    logic [31:0] epc;
    int ecnt;
  } vec_t;
  ent_t q[$];
  vec_t tbl[$];
  logic [31:0] seen[$];
  logic evld;
  logic [31:0] epc, einst;
  int n_chk = 0;
  int n_fail = 0;
  function automatic logic [31:0] mk(input logic [31:0] pc);
    return 32'h3401_1100 + pc;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_model();
    chk("id_valid", 32'(id_valid_o), 32'(evld));
    chk("id_pc", id_pc_o, epc);
    chk("id_inst", id_inst_o, einst);
    chk("count", 32'(count_o), 32'(q.size()));
    chk("if_ready", 32'(if_ready_o), 32'(q.size() < 4));
    chk("stallreq", 32'(stallreq_o), 32'(q.size() == 4));
  endtask
  task automatic clear_model();
    q.delete();
    evld = 1'b0;
    epc = '0;
    einst = '0;
  endtask
  task automatic step(input logic s1, input logic f, input logic v, input logic [31:0] pc);
    ent_t e;
    bit acc, adv;
    @(negedge clk);
    stall = {4'b0101, s1, 1'b1};
    flush = f;
    if_valid_i = v;
    if_pc_i = pc;
    if_inst_i = mk(pc);
    acc = v && q.size() < 4 && !f;
    adv = !s1 && !f;
    e = '{pc, mk(pc)};
    @(posedge clk);
    #1;
    if (f) begin
      clear_model();
    end else if (adv) begin
      if (q.size() > 0) begin
        ent_t h;
        h = q.pop_front();
        evld = 1'b1; epc = h.pc; einst = h.inst;
        if (acc) q.push_back(e);
      end else if (acc) begin
        evld = 1'b1; epc = e.pc; einst = e.inst;
      end else begin
        evld = 1'b0; epc = '0; einst = '0;
      end
      if (evld) seen.push_back(id_pc_o);
    end else if (acc) begin
      q.push_back(e);
    end
    check_model();
  endtask
  task automatic addv(input logic s, input logic f, input logic v, input logic [31:0] pc,
                      input logic ev, input logic [31:0] xpc, input int ecnt);
    tbl.push_back('{s, f, v, pc, ev, xpc, ecnt});
  endtask
  initial begin
    rst = 1'b0;
    stall = '0;
    flush = 1'b0;
    if_valid_i = 1'b0;
    if_pc_i = '0;
    if_inst_i = '0;
    clear_model();
    #12;
    check_model();
    @(negedge clk);
    rst = 1'b1;
    // bypass into an empty queue
    addv(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h0, 0);
    // fill to full under stall; fifth fetch dropped
    addv(1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 32'h0, 1);
    addv(1'b1, 1'b0, 1'b1, 32'h8, 1'b1, 32'h0, 2);
    addv(1'b1, 1'b0, 1'b1, 32'hC, 1'b1, 32'h0, 3);
    addv(1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h0, 4);
    addv(1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0, 4);
    addv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 3);
    addv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 2);
    addv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC, 1);
    addv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 0);
    addv(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 0);
    // simultaneous push and pop keeps occupancy
    addv(1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1);
    addv(1'b1, 1'b0, 1'b1, 32'h24, 1'b0, 32'h0, 2);
    addv(1'b0, 1'b0, 1'b1, 32'h28, 1'b1, 32'h20, 2);
    addv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h24, 1);
    addv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h28, 0);
    addv(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 0);
    // flush with a same-cycle fetch and stall asserted
    addv(1'b1, 1'b0, 1'b1, 32'h30, 1'b0, 32'h0, 1);
    addv(1'b1, 1'b0, 1'b1, 32'h34, 1'b0, 32'h0, 2);
    addv(1'b1, 1'b0, 1'b1, 32'h38, 1'b0, 32'h0, 3);
    addv(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 0);
    addv(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 0);
    addv(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 0);
    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].f, tbl[i].v, tbl[i].pc);
      chk("tbl_valid", 32'(id_valid_o), 32'(tbl[i].ev));
      chk("tbl_pc", id_pc_o, tbl[i].epc);
      chk("tbl_inst", id_inst_o, tbl[i].ev ? mk(tbl[i].epc) : 32'h0);
      chk("tbl_count", 32'(count_o), 32'(tbl[i].ecnt));
    end
    // asynchronous reset mid-cycle with a live output and three queued entries
    step(1'b0, 1'b0, 1'b1, 32'h1F0);
    step(1'b1, 1'b0, 1'b1, 32'h200);
    step(1'b1, 1'b0, 1'b1, 32'h204);
    step(1'b1, 1'b0, 1'b1, 32'h208);
    chk("pre_reset_count", 32'(count_o), 32'd3);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(id_valid_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_ready", 32'(if_ready_o), 32'd1);
    chk("rst_stallreq", 32'(stallreq_o), 32'd0);
    chk("rst_inst", id_inst_o, 32'd0);
    clear_model();
    if_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    // pointer wrap: alternating fill and drain phases over ten fetches
    seen.delete();
    begin
      int nxt = 0;
      for (int c = 0; c < 27; c++) begin
        logic s1, v;
        s1 = ((c / 3) % 2) == 0;
        v = s1 && nxt < 10;
        if (v && q.size() < 4) begin
          step(s1, 1'b0, 1'b1, 32'h100 + 32'(4 * nxt));
          nxt++;
        end else begin
          step(s1, 1'b0, 1'b0, 32'h0);
        end
      end
    end
    chk("wrap_outputs", 32'(seen.size()), 32'd10);
    for (int i = 0; i < 10 && i < seen.size(); i++)
      chk("wrap_order", seen[i], 32'h100 + 32'(4 * i));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
